// File: rtl/tsu_reader_pkg.sv
// tsu_reader_pkg: reader FSM states and tsu_queue word layout
package tsu_reader_pkg;
  typedef enum logic [1:0] {IDLE, RD, CAP, HOLD} state_t;
  localparam int Q_W = 92;
  localparam int SEC_LSB = 32;
  localparam int SEC_W = 48;
  localparam int NS_LSB = 0;
  localparam int NS_W = 32;
  localparam int SEQ_LSB = 80;
  localparam int SEQ_W = 8;
  localparam int TYPE_LSB = 88;
  localparam int TYPE_W = 4;
endpackage

// File: rtl/tsu_queue_reader.sv
// tsu_queue_reader: drains tsu_queue entries to a valid/ready port; TSU_READER_FILTER_EN adds per-type filtering
module tsu_queue_reader
  import tsu_reader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              q_rd_clk,
  input  logic              q_rst,
  input  logic [7:0]        q_rd_stat,
  output logic              q_rd_en,
  input  logic [Q_W-1:0]    q_rd_data,
  input  logic              flush,
  input  logic [15:0]       filter_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEC_W-1:0]  out_ts_sec,
  output logic [NS_W-1:0]   out_ts_ns,
  output logic [TYPE_W-1:0] out_msg_type,
  output logic [SEQ_W-1:0]  out_seq_lo,
  output logic [CNT_W-1:0]  cnt_consumed,
  output logic [CNT_W-1:0]  cnt_discarded
);
  state_t state, next;
  logic stat_nz;
  logic drop;
  logic [TYPE_W-1:0] typ;
  assign typ = q_rd_data[TYPE_LSB +: TYPE_W];
`ifdef TSU_READER_FILTER_EN
  assign drop = flush | ~filter_mask[typ];
`else
  logic unused_mask;
  assign unused_mask = ^filter_mask;
  assign drop = flush;
`endif
  // registered fill status decouples the queue's status path from the FSM
  always_comb begin
    next = state == IDLE ? (stat_nz ? RD : IDLE) :
           state == RD   ? CAP :
           state == CAP  ? (drop ? IDLE : HOLD) :
           (flush || out_ready) ? IDLE : HOLD;
  end
  always_ff @(posedge q_rd_clk) begin
    if (q_rst) begin
      state <= IDLE;
      stat_nz <= 1'b0;
      q_rd_en <= 1'b0;
      out_valid <= 1'b0;
      out_ts_sec <= '0;
      out_ts_ns <= '0;
      out_msg_type <= '0;
      out_seq_lo <= '0;
      cnt_consumed <= '0;
      cnt_discarded <= '0;
    end else begin
      state <= next;
      stat_nz <= |q_rd_stat;
      q_rd_en <= next == RD;
      out_valid <= next == HOLD;
      if (state == CAP) begin
        out_ts_sec <= q_rd_data[SEC_LSB +: SEC_W];
        out_ts_ns <= q_rd_data[NS_LSB +: NS_W];
        out_msg_type <= typ;
        out_seq_lo <= q_rd_data[SEQ_LSB +: SEQ_W];
      end
      if ((state == CAP && drop) || (state == HOLD && flush))
        cnt_discarded <= cnt_discarded + CNT_W'(1);
      if (state == HOLD && !flush && out_ready)
        cnt_consumed <= cnt_consumed + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_tsu_queue_reader.sv
// tb_tsu_queue_reader: queue model plus scoreboard bench for tsu_queue_reader (CNT_W=4)
module tb_tsu_queue_reader;
`ifdef TSU_READER_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [7:0] q_rd_stat = '0;
  logic q_rd_en;
  logic [91:0] q_rd_data = '0;
  logic flush;
  logic [15:0] filter_mask;
  logic out_valid;
  logic out_ready;
  logic [47:0] out_ts_sec;
  logic [31:0] out_ts_ns;
  logic [3:0] out_msg_type;
  logic [7:0] out_seq_lo;
  logic [3:0] cnt_consumed;
  logic [3:0] cnt_discarded;
  int checks = 0;
  int failures = 0;
  int rd_pulses = 0;
  int underflow = 0;
  int valid_seen = 0;
  logic prev_en = 1'b0;
  logic [91:0] fifo[$];
  logic [91:0] exp_q[$];
  logic [91:0] e;
  logic [3:0] exp_cons = '0;
  logic [3:0] exp_disc = '0;
  typedef struct {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [3:0] typ;
    logic [7:0] seq;
    logic fl;
    logic [15:0] mask;
    bit pres_f;
    bit pres_n;
  } vec_t;
  vec_t vecs[9];
  tsu_queue_reader #(.CNT_W(4)) dut (
    .q_rd_clk(clk), .q_rst(rst), .q_rd_stat(q_rd_stat), .q_rd_en(q_rd_en),
    .q_rd_data(q_rd_data), .flush(flush), .filter_mask(filter_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts_sec(out_ts_sec),
    .out_ts_ns(out_ts_ns), .out_msg_type(out_msg_type), .out_seq_lo(out_seq_lo),
    .cnt_consumed(cnt_consumed), .cnt_discarded(cnt_discarded)
  );
  always #5 clk = ~clk;
  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      fifo.delete();
      q_rd_data <= '0;
    end else if (q_rd_en) begin
      rd_pulses++;
      if (fifo.size() == 0) underflow++;
      else q_rd_data <= fifo.pop_front();
    end
  end
  always @(negedge clk) begin
    q_rd_stat <= 8'(fifo.size());
    valid_seen += int'(out_valid);
    if (q_rd_en && prev_en) check("rd_en_width", 2, 1);
    prev_en <= q_rd_en;
    if (out_valid && out_ready && !flush && !rst) begin
      if (exp_q.size() == 0) check("unexpected_entry", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("entry_fields", {out_msg_type, out_seq_lo, out_ts_sec, out_ts_ns}, e);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] t, input logic [7:0] s, input logic [47:0] sec,
                      input logic [31:0] ns, input bit pres);
    logic [91:0] w;
    w = {t, s, sec, ns};
    fifo.push_back(w);
    if (pres) begin
      exp_q.push_back(w);
      exp_cons++;
    end else exp_disc++;
  endtask
  task automatic drain(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 400) begin
      tick();
      n++;
      quiet = (fifo.size() == 0 && !out_valid && !q_rd_en) ? quiet + 1 : 0;
    end
    if (quiet < 4) check({name, "_drain_timeout"}, 0, 1);
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) check({name, "_valid_timeout"}, 0, 1);
  endtask
  task automatic check_counts(input string name);
    check({name, "_consumed"}, cnt_consumed, exp_cons);
    check({name, "_discarded"}, cnt_discarded, exp_disc);
  endtask
  initial begin
    logic [91:0] snap;
    int r0, v0, bad;
    vecs[0] = '{48'h000000000123, 32'h00000456, 4'h3, 8'h7A, 1'b0, 16'hFFFF, 1'b1, 1'b1};
    vecs[1] = '{48'hFFFFFFFFFFFF, 32'hFFFFFFFF, 4'hF, 8'hFF, 1'b0, 16'hFFFF, 1'b1, 1'b1};
    vecs[2] = '{48'h0, 32'h0, 4'h0, 8'h00, 1'b0, 16'hFFFF, 1'b1, 1'b1};
    vecs[3] = '{48'hA5A5A5A5A5A5, 32'h5A5A5A5A, 4'hA, 8'h5A, 1'b0, 16'hFFFF, 1'b1, 1'b1};
    vecs[4] = '{48'h00000000BEEF, 32'h12345678, 4'h2, 8'h11, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[5] = '{48'h000000000001, 32'h00000002, 4'h0, 8'h03, 1'b0, 16'h0001, 1'b1, 1'b1};
    vecs[6] = '{48'h000000000004, 32'h00000005, 4'h1, 8'h06, 1'b0, 16'h0001, 1'b0, 1'b1};
    vecs[7] = '{48'h800000000000, 32'h80000000, 4'hF, 8'h80, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[8] = '{48'h000000000777, 32'h00000888, 4'h0, 8'h99, 1'b0, 16'hFFFE, 1'b0, 1'b1};
    rst = 1'b1;
    flush = 1'b0;
    filter_mask = 16'hFFFF;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_valid", out_valid, 0);
    check("reset_rd_en", q_rd_en, 0);
    check("reset_fields", {out_msg_type, out_seq_lo, out_ts_sec, out_ts_ns}, 0);
    check_counts("reset");
    for (int i = 0; i < 9; i++) begin
      flush = vecs[i].fl;
      filter_mask = vecs[i].mask;
      r0 = rd_pulses;
      push(vecs[i].typ, vecs[i].seq, vecs[i].sec, vecs[i].ns, FILT ? vecs[i].pres_f : vecs[i].pres_n);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d_rd_pulses", i), rd_pulses - r0, 1);
      check_counts($sformatf("vec%0d", i));
    end
    flush = 1'b0;
    filter_mask = 16'hFFFF;
    out_ready = 1'b0;
    push(4'h5, 8'h42, 48'h0000DEADBEEF, 32'h0BADF00D, 1'b1);
    tick();
    check("lat_n_rd_en", q_rd_en, 0);
    tick();
    check("lat_n1_rd_en", q_rd_en, 1);
    tick();
    check("lat_n2_rd_en", q_rd_en, 0);
    check("lat_n2_valid", out_valid, 0);
    tick();
    check("lat_n3_valid", out_valid, 1);
    out_ready = 1'b1;
    drain("lat");
    check_counts("lat");
    out_ready = 1'b0;
    push(4'h1, 8'h01, 48'h000000000011, 32'h00000111, 1'b1);
    push(4'h2, 8'h02, 48'h000000000022, 32'h00000222, 1'b1);
    push(4'h3, 8'h03, 48'h000000000033, 32'h00000333, 1'b1);
    wait_valid("bp");
    snap = {out_msg_type, out_seq_lo, out_ts_sec, out_ts_ns};
    check("bp_first", snap, {4'h1, 8'h01, 48'h000000000011, 32'h00000111});
    r0 = rd_pulses;
    bad = 0;
    repeat (20) begin
      tick();
      if (!out_valid || {out_msg_type, out_seq_lo, out_ts_sec, out_ts_ns} !== snap) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_no_rd", rd_pulses - r0, 0);
    out_ready = 1'b1;
    drain("bp");
    check_counts("bp");
    flush = 1'b1;
    r0 = rd_pulses;
    v0 = valid_seen;
    for (int i = 0; i < 5; i++) push(4'(i), 8'(i), 48'(i), 32'(i), 1'b0);
    drain("flush");
    check("flush_rd_pulses", rd_pulses - r0, 5);
    check("flush_no_valid", valid_seen - v0, 0);
    check("flush_stat", q_rd_stat, 0);
    check_counts("flush");
    flush = 1'b0;
    filter_mask = 16'h0001;
    push(4'h0, 8'hA0, 48'h0000000000A0, 32'h000000A0, 1'b1);
    push(4'h1, 8'hA1, 48'h0000000000A1, 32'h000000A1, !FILT);
    push(4'h0, 8'hA2, 48'h0000000000A2, 32'h000000A2, 1'b1);
    drain("filter");
    check_counts("filter");
    filter_mask = 16'hFFFF;
    out_ready = 1'b0;
    push(4'h6, 8'h66, 48'h000000000066, 32'h00000066, 1'b0);
    wait_valid("hflush");
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    check("hflush_valid", out_valid, 0);
    check_counts("hflush");
    flush = 1'b0;
    drain("hflush");
    check_counts("hflush_after");
    out_ready = 1'b0;
    push(4'h7, 8'h77, 48'h000000000077, 32'h00000077, 1'b0);
    wait_valid("mrst");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cons = '0;
    exp_disc = '0;
    check("mrst_valid", out_valid, 0);
    check("mrst_rd_en", q_rd_en, 0);
    check("mrst_fields", {out_msg_type, out_seq_lo, out_ts_sec, out_ts_ns}, 0);
    check_counts("mrst");
    r0 = rd_pulses;
    repeat (6) tick();
    check("mrst_no_rd", rd_pulses - r0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(4'(i), 8'(i + 16), 48'(i * 3), 32'(i * 5), 1'b1);
    drain("wrap");
    check("wrap_consumed", cnt_consumed, 4'd1);
    check_counts("wrap");
    check("no_underflow", underflow, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
